// File: rtl/beam_mux.sv
// -----------------------------------------------------------------------------
// beam_mux
//   Registered 1-to-N AXI-Stream demultiplexer between the beam modulator and
//   up to three DAC streams. Each packet (delimited by mod_t_last) is steered
//   whole to the output chosen by dac_sel, which is sampled on the first
//   accepted beat of the packet. Data passes through unmodified with one cycle
//   of latency.
//
//   Parameter
//     N_BEAM_MUX_DACS : number of enabled DAC outputs (1..3, >3 treated as 3)
//
//   Ports
//     clk                 : single clock, rising edge
//     rst                 : asynchronous reset, active low
//     dac_sel[1:0]        : target output for the next packet (0..2 -> dac1..dac3)
//     mod_t_data/valid/last, mod_t_ready : input AXI-Stream
//     dacN_t_data/valid/tlast, dacN_t_ready : output AXI-Stream N (N = 1..3)
//
//   Configuration macro
//     BEAM_MUX_BACKPRESSURE_EN : when defined, each output owns a 2-entry skid
//       buffer and honours dacN_t_ready; otherwise outputs are always ready and
//       dacN_t_ready is ignored.
// -----------------------------------------------------------------------------
module beam_mux #(
   parameter int unsigned N_BEAM_MUX_DACS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  dac_sel,
   input  logic [31:0] mod_t_data,
   input  logic        mod_t_valid,
   output logic        mod_t_ready,
   input  logic        mod_t_last,
   output logic [31:0] dac1_t_data,
   output logic        dac1_t_valid,
   input  logic        dac1_t_ready,
   output logic        dac1_t_tlast,
   output logic [31:0] dac2_t_data,
   output logic        dac2_t_valid,
   input  logic        dac2_t_ready,
   output logic        dac2_t_tlast,
   output logic [31:0] dac3_t_data,
   output logic        dac3_t_valid,
   input  logic        dac3_t_ready,
   output logic        dac3_t_tlast
);

   localparam int unsigned N_EFF = (N_BEAM_MUX_DACS > 3) ? 3 : N_BEAM_MUX_DACS;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_sel;
   logic [1:0]  w_sel_nxt;
   logic [1:0]  w_sel;
   logic        w_tgt_ok;
   logic        w_acc;
   logic [2:0]  w_push;
   logic        r_rdy;

   logic [31:0] w_out_data [3];
   logic [2:0]  w_out_valid;
   logic [2:0]  w_out_last;

   // ---------------------------------------------------------------------------
   // Packet tracking FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      case (r_state)
         ST_IDLE: begin
            if (w_acc) begin
               w_sel_nxt = dac_sel;
               if (!mod_t_last) begin
                  w_state_nxt = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (w_acc && mod_t_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // First beat of a packet routes on the live select; later beats use the
   // value latched on that first beat.
   always_comb begin
      w_sel    = (r_state == ST_IDLE) ? dac_sel : r_sel;
      w_tgt_ok = (32'(w_sel) < N_EFF);
   end

   assign w_acc = mod_t_valid & mod_t_ready;

   always_comb begin
      w_push = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         w_push[k] = w_acc && w_tgt_ok && (w_sel == 2'(k));
      end
   end

   // Input ready comes up on the first edge after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
      end
   end

`ifdef BEAM_MUX_BACKPRESSURE_EN
   // ---------------------------------------------------------------------------
   // Per-output 2-entry skid buffer: q0 is the head presented on the port.
   // ---------------------------------------------------------------------------
   logic [31:0] r_q0_d [3];
   logic [31:0] r_q1_d [3];
   logic [2:0]  r_q0_l;
   logic [2:0]  r_q1_l;
   logic [1:0]  r_cnt  [3];
   logic [2:0]  w_dac_rdy;
   logic [2:0]  w_pop;
   logic        w_free;

   assign w_dac_rdy = {dac3_t_ready, dac2_t_ready, dac1_t_ready};

   always_comb begin
      w_pop  = '0;
      w_free = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         w_pop[k] = (r_cnt[k] != 2'd0) && w_dac_rdy[k];
         if ((w_sel == 2'(k)) && (r_cnt[k] == 2'd2)) begin
            w_free = 1'b0;
         end
      end
   end

   // Ready looks only at registered occupancy, so a full buffer stalls the
   // input even if its head retires this cycle; one entry of slack keeps
   // 1 beat/cycle when the output is continuously ready.
   assign mod_t_ready = r_rdy && (!w_tgt_ok || w_free);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < 3; k++) begin
            r_q0_d[k] <= '0;
            r_q1_d[k] <= '0;
            r_cnt[k]  <= '0;
         end
         r_q0_l <= '0;
         r_q1_l <= '0;
      end else begin
         for (int unsigned k = 0; k < 3; k++) begin
            case ({w_push[k], w_pop[k]})
               2'b01: begin
                  r_q0_d[k] <= r_q1_d[k];
                  r_q0_l[k] <= r_q1_l[k];
                  r_cnt[k]  <= r_cnt[k] - 2'd1;
               end
               2'b10: begin
                  if (r_cnt[k] == 2'd0) begin
                     r_q0_d[k] <= mod_t_data;
                     r_q0_l[k] <= mod_t_last;
                  end else begin
                     r_q1_d[k] <= mod_t_data;
                     r_q1_l[k] <= mod_t_last;
                  end
                  r_cnt[k] <= r_cnt[k] + 2'd1;
               end
               2'b11: begin
                  // Push is only possible below full, so with a pop the new
                  // beat lands in the head if it was the only entry.
                  if (r_cnt[k] == 2'd1) begin
                     r_q0_d[k] <= mod_t_data;
                     r_q0_l[k] <= mod_t_last;
                  end else begin
                     r_q0_d[k] <= r_q1_d[k];
                     r_q0_l[k] <= r_q1_l[k];
                     r_q1_d[k] <= mod_t_data;
                     r_q1_l[k] <= mod_t_last;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < 3; k++) begin
         w_out_data[k]  = r_q0_d[k];
         w_out_valid[k] = (r_cnt[k] != 2'd0);
         w_out_last[k]  = r_q0_l[k] && (r_cnt[k] != 2'd0);
      end
   end
`else
   // ---------------------------------------------------------------------------
   // Outputs always ready: a single output register stage per DAC.
   // ---------------------------------------------------------------------------
   logic [31:0] r_data [3];
   logic [2:0]  r_valid;
   logic [2:0]  r_last;
   logic        w_unused;

   assign w_unused    = &{1'b0, dac1_t_ready, dac2_t_ready, dac3_t_ready};
   assign mod_t_ready = r_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < 3; k++) begin
            r_data[k] <= '0;
         end
         r_valid <= '0;
         r_last  <= '0;
      end else begin
         r_valid <= w_push;
         r_last  <= w_push & {3{mod_t_last}};
         for (int unsigned k = 0; k < 3; k++) begin
            if (w_push[k]) begin
               r_data[k] <= mod_t_data;
            end
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < 3; k++) begin
         w_out_data[k] = r_data[k];
      end
      w_out_valid = r_valid;
      w_out_last  = r_last;
   end
`endif

   assign dac1_t_data  = w_out_data[0];
   assign dac1_t_valid = w_out_valid[0];
   assign dac1_t_tlast = w_out_last[0];
   assign dac2_t_data  = w_out_data[1];
   assign dac2_t_valid = w_out_valid[1];
   assign dac2_t_tlast = w_out_last[1];
   assign dac3_t_data  = w_out_data[2];
   assign dac3_t_valid = w_out_valid[2];
   assign dac3_t_tlast = w_out_last[2];

endmodule

// File: tb/tb_beam_mux.sv
// -----------------------------------------------------------------------------
// tb_beam_mux
//   Self-checking bench for beam_mux. A packet-level reference model keeps one
//   queue of expected beats per DAC; a beat is queued when the model accepts it
//   and leaves the queue when the DAC presents it and it retires.
// -----------------------------------------------------------------------------
module tb_beam_mux;

   localparam int unsigned N = 3;
`ifdef BEAM_MUX_BACKPRESSURE_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic        clk;
   logic        rst;
   logic [1:0]  dac_sel;
   logic [31:0] mod_t_data;
   logic        mod_t_valid;
   logic        mod_t_ready;
   logic        mod_t_last;
   logic [31:0] dac1_t_data, dac2_t_data, dac3_t_data;
   logic        dac1_t_valid, dac2_t_valid, dac3_t_valid;
   logic        dac1_t_tlast, dac2_t_tlast, dac3_t_tlast;
   logic [2:0]  rdy;

   logic [31:0] o_d [3];
   logic [2:0]  o_v;
   logic [2:0]  o_l;

   beat_t       exp_q [3][$];
   bit          in_pkt;
   logic [1:0]  pkt_sel;
   int          hold_lo;
   bit          rdy_rand;
   int          checks;
   int          errors;

   beam_mux #(.N_BEAM_MUX_DACS(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .dac_sel      (dac_sel),
      .mod_t_data   (mod_t_data),
      .mod_t_valid  (mod_t_valid),
      .mod_t_ready  (mod_t_ready),
      .mod_t_last   (mod_t_last),
      .dac1_t_data  (dac1_t_data),
      .dac1_t_valid (dac1_t_valid),
      .dac1_t_ready (rdy[0]),
      .dac1_t_tlast (dac1_t_tlast),
      .dac2_t_data  (dac2_t_data),
      .dac2_t_valid (dac2_t_valid),
      .dac2_t_ready (rdy[1]),
      .dac2_t_tlast (dac2_t_tlast),
      .dac3_t_data  (dac3_t_data),
      .dac3_t_valid (dac3_t_valid),
      .dac3_t_ready (rdy[2]),
      .dac3_t_tlast (dac3_t_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      o_d[0] = dac1_t_data;
      o_d[1] = dac2_t_data;
      o_d[2] = dac3_t_data;
      o_v    = {dac3_t_valid, dac2_t_valid, dac1_t_valid};
      o_l    = {dac3_t_tlast, dac2_t_tlast, dac1_t_tlast};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic step(input logic v, input logic [31:0] d, input logic l,
                       input logic [1:0] s, output bit acc);
      logic [1:0] tgt;
      bit         exp_rdy;
      beat_t      b;
      mod_t_valid = v;
      mod_t_data  = d;
      mod_t_last  = l;
      dac_sel     = s;
      rdy         = rdy_rand ? 3'($urandom) : 3'b111;
      if (hold_lo > 0) begin
         rdy[0] = 1'b0;
         hold_lo--;
      end
      #1;
      tgt = in_pkt ? pkt_sel : s;
      if (!BP || tgt >= N) exp_rdy = 1'b1;
      else                 exp_rdy = (exp_q[tgt].size() < 2);
      chk("mod_t_ready", mod_t_ready, exp_rdy);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dac%0d_valid", k + 1), o_v[k], exp_q[k].size() != 0);
         if (o_v[k] && exp_q[k].size() != 0) begin
            chk($sformatf("dac%0d_data", k + 1), o_d[k], exp_q[k][0].d);
            chk($sformatf("dac%0d_tlast", k + 1), o_l[k], exp_q[k][0].l);
            if (!BP || rdy[k]) void'(exp_q[k].pop_front());
         end
      end
      acc = v && exp_rdy;
      if (acc) begin
         if (tgt < N) begin
            b.d = d;
            b.l = l;
            exp_q[tgt].push_back(b);
         end
         if (!in_pkt) begin
            pkt_sel = s;
            in_pkt  = !l;
         end else if (l) begin
            in_pkt = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l, input logic [1:0] s);
      bit acc;
      int n;
      n = 0;
      do begin
         step(1'b1, d, l, s, acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         checks++;
         errors++;
         $error("FAIL accept_timeout observed=stalled expected=accepted");
      end
   endtask

   // mode 0: fixed select; 1: random select after first beat;
   // 2: select switches to 1 at beat 10; 3: dac1 stalled 5 cycles at beat 100
   task automatic send_pkt(input int len, input logic [1:0] sel, input int mode,
                           input bit seq, input int gap_pct);
      logic [1:0]  s;
      logic [31:0] d;
      bit          acc;
      for (int i = 0; i < len; i++) begin
         while (int'($urandom_range(99)) < gap_pct)
            step(1'b0, $urandom, 1'b0, 2'($urandom), acc);
         s = sel;
         if (mode == 1 && i > 0) s = 2'($urandom);
         if (mode == 2 && i >= 10) s = 2'd1;
         if (mode == 3 && i == 100) hold_lo = 5;
         d = seq ? 32'(i) : $urandom;
         send_beat(d, (i == len - 1), s);
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
         step(1'b0, $urandom, 1'b0, 2'($urandom), acc);
         n++;
      end
      step(1'b0, $urandom, 1'b0, 2'($urandom), acc);
      for (int k = 0; k < 3; k++)
         chk($sformatf("dac%0d_drained", k + 1), exp_q[k].size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, mod_t_ready, 1'b0);
      chk({tag, "_valid"}, o_v, 3'b000);
      chk({tag, "_tlast"}, o_l, 3'b000);
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s_data%0d", tag, k + 1), o_d[k], 32'd0);
   endtask

   initial begin
      bit acc;
      checks      = 0;
      errors      = 0;
      in_pkt      = 1'b0;
      pkt_sel     = '0;
      hold_lo     = 0;
      rdy_rand    = 1'b0;
      rst         = 1'b0;
      dac_sel     = '0;
      mod_t_data  = '0;
      mod_t_valid = 1'b0;
      mod_t_last  = 1'b0;
      rdy         = 3'b111;

      // Reset state, ready rising on the first edge after release
      #3;
      chk_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_held");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_release_ready", mod_t_ready, 1'b0);
      @(posedge clk);
      #1;

      // Counting packet to dac1, continuous beats
      send_pkt(1024, 2'd0, 0, 1'b1, 0);
      drain();

      // Back-to-back packets to dac1/2/3, select wiggling mid-packet
      send_pkt(1024, 2'd0, 1, 1'b0, 0);
      send_pkt(1024, 2'd1, 1, 1'b0, 0);
      send_pkt(1024, 2'd2, 1, 1'b0, 0);
      drain();

      // Select change during a packet applies only to the next packet
      send_pkt(40, 2'd0, 2, 1'b0, 0);
      send_pkt(20, 2'd1, 0, 1'b0, 0);
      drain();

      // Invalid target: accepted and dropped, next packet routed normally
      send_pkt(8, 2'd3, 0, 1'b0, 0);
      send_pkt(8, 2'd2, 0, 1'b0, 0);
      send_pkt(1, 2'd3, 0, 1'b0, 0);
      send_pkt(1, 2'd1, 0, 1'b0, 0);
      drain();

      // Randomized packets, gaps and (ignored unless buffered) output ready
      rdy_rand = 1'b1;
      for (int p = 0; p < 60; p++)
         send_pkt(int'($urandom_range(1, 20)), 2'($urandom), 1, 1'b0, 25);
      rdy_rand = 1'b0;
      drain();

      // Output stall mid-stream on dac1
      send_pkt(1024, 2'd0, 3, 1'b1, 0);
      drain();

      // Reset in the middle of a packet: abandoned beats never appear
      send_pkt(1, 2'd1, 0, 1'b0, 0);
      step(1'b1, $urandom, 1'b0, 2'd1, acc);
      step(1'b1, $urandom, 1'b0, 2'd1, acc);
      rst = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      in_pkt = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(12, 2'd2, 0, 1'b0, 10);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
